// File: rtl/gpu_pkg.sv
// Shared constants for the MAC accumulator slice.
// State encoding and default widths.
package gpu_pkg;
  localparam int ACC_W_DEF = 32;
  localparam int LEN_W_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
endpackage

// File: rtl/sat_adder.sv
// Unsigned W-bit adder: wraps, or clamps when
// ACC_SATURATE_EN is defined. a,b in; sum,ovf out.
module sat_adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

`ifdef ACC_SATURATE_EN
  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign sum  = full[W] ? '1 : full[W-1:0];
  assign ovf  = full[W];
`else
  assign sum = a + b;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/mac_accumulator.sv
// Dot-product accumulator: IDLE/ACCUM/DONE FSM.
// In: start,length,prod_valid,prod,prod_skipped,out_ready
// Out: busy,out_valid,acc_out,skip_count,overflow
// Option: ACC_SATURATE_EN clamps sums at all-ones.
module mac_accumulator
  import gpu_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] length,
  input  logic             prod_valid,
  input  logic [15:0]      prod,
  input  logic             prod_skipped,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [ACC_W-1:0] acc_out,
  output logic [LEN_W-1:0] skip_count,
  output logic             overflow
);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W-1:0] skip_q, skip_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             accept;

  assign prod_ext = ACC_W'(prod);

  sat_adder #(
    .W(ACC_W)
  ) u_add (
    .a  (acc_q),
    .b  (prod_ext),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  // A finished result is released in the same
  // cycle a new operation is accepted.
  assign accept = start &
    ((state_q == ST_IDLE) |
     ((state_q == ST_DONE) & out_ready));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    skip_d  = skip_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    if (accept) begin
      acc_d  = '0;
      skip_d = '0;
      ovf_d  = 1'b0;
      rem_d  = length;
      if (length == '0) state_d = ST_DONE;
      else              state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ACCUM: begin
          if (prod_valid) begin
            rem_d = rem_q - LEN_W'(1);
            if (prod_skipped) begin
              if (skip_q != '1)
                skip_d = skip_q + LEN_W'(1);
            end else begin
              acc_d = add_sum;
              ovf_d = ovf_q | add_ovf;
            end
            if (rem_q == LEN_W'(1))
              state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      skip_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      skip_q  <= skip_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign acc_out    = acc_q;
  assign skip_count = skip_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Randomized self-checking bench for mac_accumulator.
// Reference model: plain sum/count over product lists.
module tb_mac_accumulator;

  localparam int AW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] length;
  logic          prod_valid;
  logic [15:0]   prod;
  logic          prod_skipped;
  logic          out_ready;
  logic          busy;
  logic          out_valid;
  logic [AW-1:0] acc_out;
  logic [LW-1:0] skip_count;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  int p_q[$];
  bit s_q[$];

  always #5 clk = ~clk;

  mac_accumulator #(
    .ACC_W(AW),
    .LEN_W(LW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .length      (length),
    .prod_valid  (prod_valid),
    .prod        (prod),
    .prod_skipped(prod_skipped),
    .out_ready   (out_ready),
    .busy        (busy),
    .out_valid   (out_valid),
    .acc_out     (acc_out),
    .skip_count  (skip_count),
    .overflow    (overflow)
  );

  task automatic check(input string tag,
                       input longint got,
                       input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected result from the spec's arithmetic:
  // total of non-skipped products, then wrap or clamp.
  task automatic model(output longint e_acc,
                       output longint e_skip,
                       output longint e_ovf);
    longint total = 0;
    longint maxv  = (64'd1 << AW) - 1;
    e_skip = 0;
    foreach (p_q[i]) begin
      if (s_q[i]) e_skip++;
      else        total += p_q[i];
    end
`ifdef ACC_SATURATE_EN
    e_ovf = (total > maxv) ? 1 : 0;
    e_acc = (total > maxv) ? maxv : total;
`else
    e_ovf = 0;
    e_acc = total % (maxv + 1);
`endif
  endtask

  task automatic run_op(input string tag,
                        input int gmin,
                        input int gmax);
    longint ea, es, eo;
    int n = p_q.size();
    model(ea, es, eo);
    start  = 1'b1;
    length = LW'(n);
    tick();
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      int g = $urandom_range(gmax, gmin);
      prod_valid = 1'b0;
      repeat (g) tick();
      prod_valid   = 1'b1;
      prod         = 16'(p_q[i]);
      prod_skipped = s_q[i];
      tick();
      prod_valid = 1'b0;
      if (i < n - 1)
        check({tag, "_early"}, out_valid, 0);
      prod = 16'($urandom);
    end
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_acc"}, acc_out, ea);
    check({tag, "_skp"}, skip_count, es);
    check({tag, "_ovf"}, overflow, eo);
  endtask

  task automatic accept(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, busy, 0);
  endtask

  task automatic hold(input string tag, input int n);
    logic [AW-1:0] a0 = acc_out;
    logic [LW-1:0] s0 = skip_count;
    logic          o0 = overflow;
    repeat (n) begin
      tick();
      check({tag, "_hv"}, out_valid, 1);
      check({tag, "_ha"}, acc_out, a0);
      check({tag, "_hs"}, skip_count, s0);
      check({tag, "_ho"}, overflow, o0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    length = '0;
    prod_valid = 1'b0;
    prod = '0;
    prod_skipped = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_vld", out_valid, 0);
    check("rst_acc", acc_out, 0);
    check("rst_skp", skip_count, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick();

    p_q = '{3, 123, 5, 7};
    s_q = '{0, 1, 0, 0};
    run_op("b2b", 0, 0);
    check("b2b_15", acc_out, 15);
    accept("b2b");

    run_op("gap", 1, 3);
    check("gap_15", acc_out, 15);
    hold("gap", 5);
    accept("gap");

    p_q.delete();
    s_q.delete();
    run_op("len0", 0, 0);
    accept("len0");

    p_q = '{16'hFFFF, 16'h0002};
    s_q = '{0, 0};
    run_op("sat", 0, 0);
`ifdef ACC_SATURATE_EN
    check("sat_max", acc_out, 16'hFFFF);
    check("sat_flag", overflow, 1);
`else
    check("wrap_val", acc_out, 16'h0001);
    check("wrap_flag", overflow, 0);
`endif
    accept("sat");

    start = 1'b1;
    length = 8'd4;
    tick();
    start = 1'b0;
    prod_valid = 1'b1;
    prod = 16'd3;
    tick();
    prod = 16'd5;
    tick();
    prod_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_busy", busy, 0);
    check("mrst_acc", acc_out, 0);
    prod_valid = 1'b1;
    repeat (3) begin
      tick();
      check("mrst_vld", out_valid, 0);
      check("mrst_idle", busy, 0);
    end
    prod_valid = 1'b0;
    p_q = '{9};
    s_q = '{0};
    run_op("after_rst", 0, 0);
    check("after_rst_9", acc_out, 9);
    accept("after_rst");

    p_q = '{4, 6};
    s_q = '{0, 0};
    run_op("chain", 0, 0);
    start = 1'b1;
    length = 8'd2;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("chain_busy", busy, 1);
    check("chain_vld", out_valid, 0);
    length = 8'd5;
    prod_valid = 1'b1;
    prod = 16'd1;
    prod_skipped = 1'b0;
    tick();
    start = 1'b0;
    prod = 16'd2;
    tick();
    prod_valid = 1'b0;
    check("chain_done", out_valid, 1);
    check("chain_acc", acc_out, 3);
    check("chain_skp", skip_count, 0);
    accept("chain");
    prod_valid = 1'b1;
    prod = 16'd100;
    repeat (3) begin
      tick();
      check("idle_busy", busy, 0);
      check("idle_vld", out_valid, 0);
      check("idle_acc", acc_out, 3);
    end
    prod_valid = 1'b0;

    for (int t = 0; t < 25; t++) begin
      int n = $urandom_range(6, 1);
      p_q.delete();
      s_q.delete();
      for (int i = 0; i < n; i++) begin
        p_q.push_back(int'($urandom_range(16'hFFFF, 0)));
        s_q.push_back(($urandom_range(3, 0) == 0));
      end
      run_op("rnd", 0, 2);
      hold("rnd", $urandom_range(3, 0));
      accept("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
